// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the arbiter's request/response buses: display read port, drawing
// writer port, clear control and the single-port framebuffer RAM port.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_valid;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    output disp_rdata, disp_valid, wr_ack, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data,
           clr_start, clr_color, mem_rdata,
    input  disp_rdata, disp_valid, wr_ack, clr_busy,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: display reads > drawing writes > background clear,
// one registered RAM access per pixel clock.
module vga_fb_arbiter #(
  parameter int FB_WORDS = 19200,
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8
) (
  input logic              clk_pixel,
  input logic              rst_n,
  vga_fb_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  // One extra bit so FB_WORDS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W+1)'(FB_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color_q;
  logic              clr_busy_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              disp_p1, disp_p2;
  logic              disp_ok_p1, disp_ok_p2;

  logic              disp_in_range;
  logic              wr_in_range;
  logic              clr_grant;

  assign disp_in_range = {1'b0, bus.disp_addr} < FB_LIMIT;
  assign wr_in_range   = {1'b0, bus.wr_addr} < FB_LIMIT;
  assign clr_grant     = (state == CLEAR) && !bus.disp_req && !bus.wr_req;

  assign bus.wr_ack     = bus.wr_req & ~bus.disp_req;
  assign bus.clr_busy   = clr_busy_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.disp_valid = disp_p2;
  // Out-of-range reads never touched the RAM, so their data is forced to zero.
  assign bus.disp_rdata = disp_ok_p2 ? bus.mem_rdata : '0;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (bus.disp_req) begin
      mem_en_q   <= disp_in_range;
      mem_we_q   <= 1'b0;
      mem_addr_q <= bus.disp_addr;
    end else if (bus.wr_req) begin
      mem_en_q    <= wr_in_range;
      mem_we_q    <= wr_in_range;
      mem_addr_q  <= bus.wr_addr;
      mem_wdata_q <= bus.wr_data;
    end else if (clr_grant) begin
      mem_en_q    <= 1'b1;
      mem_we_q    <= 1'b1;
      mem_addr_q  <= clr_cnt;
      mem_wdata_q <= clr_color_q;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      disp_p1    <= 1'b0;
      disp_p2    <= 1'b0;
      disp_ok_p1 <= 1'b0;
      disp_ok_p2 <= 1'b0;
    end else begin
      disp_p1    <= bus.disp_req;
      disp_ok_p1 <= bus.disp_req & disp_in_range;
      disp_p2    <= disp_p1;
      disp_ok_p2 <= disp_ok_p1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
      clr_busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            clr_color_q <= bus.clr_color;
            clr_cnt     <= '0;
            clr_busy_q  <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          // clr_start is deliberately ignored here; only the last write ends the clear.
          if (clr_grant) begin
            if (clr_cnt == LAST_ADDR) begin
              state      <= IDLE;
              clr_busy_q <= 1'b0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;
  localparam int FB_WORDS = 19200;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;

  logic clk_pixel;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_arbiter #(.FB_WORDS(FB_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_model[bus.mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  initial begin
    int errs, busy_cnt, wr_cnt;
    logic exp_wr, exp_valid;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clr_start = 1'b0;
    bus.clr_color = '0;
    mem_model[5] = 8'hA7;
    mem_model[1] = 8'h11;
    mem_model[2] = 8'h22;
    mem_model[3] = 8'h33;

    // Reset values
    tick;
    chk("rst_mem_en",     32'(bus.mem_en), 32'd0);
    chk("rst_mem_we",     32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata), 32'd0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("rst_disp_rdata", 32'(bus.disp_rdata), 32'd0);
    chk("rst_clr_busy",   32'(bus.clr_busy), 32'd0);
    #2 rst_n = 1'b1;
    tick;

    // Single display read of a preloaded pixel
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'h0005;
    tick;
    bus.disp_req = 1'b0;
    chk("rd_mem_en",   32'(bus.mem_en), 32'd1);
    chk("rd_mem_we",   32'(bus.mem_we), 32'd0);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h5);
    chk("rd_valid_n1", 32'(bus.disp_valid), 32'd0);
    tick;
    chk("rd_valid_n2", 32'(bus.disp_valid), 32'd1);
    chk("rd_rdata_n2", 32'(bus.disp_rdata), 32'hA7);
    chk("rd_mem_idle", 32'(bus.mem_en), 32'd0);
    tick;
    chk("rd_valid_n3", 32'(bus.disp_valid), 32'd0);
    chk("rd_rdata_n3", 32'(bus.disp_rdata), 32'd0);

    // Writer held off by three back-to-back display reads
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'h0100;
    bus.wr_data = 8'h5C;
    bus.disp_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.disp_addr = 15'(i + 1);
      #1;
      chk("wr_ack_blocked", 32'(bus.wr_ack), 32'd0);
      if (i >= 1) begin
        chk("b2b_mem_addr", 32'(bus.mem_addr), 32'(i));
        chk("b2b_mem_we",   32'(bus.mem_we), 32'd0);
      end
      if (i == 2) begin
        chk("b2b_valid_a1", 32'(bus.disp_valid), 32'd1);
        chk("b2b_rdata_a1", 32'(bus.disp_rdata), 32'h11);
      end
      tick;
    end
    bus.disp_req = 1'b0;
    #1;
    chk("wr_ack_granted", 32'(bus.wr_ack), 32'd1);
    chk("b2b_mem_addr3",  32'(bus.mem_addr), 32'h3);
    chk("b2b_valid_a2",   32'(bus.disp_valid), 32'd1);
    chk("b2b_rdata_a2",   32'(bus.disp_rdata), 32'h22);
    tick;
    bus.wr_req = 1'b0;
    chk("wr_mem_en",    32'(bus.mem_en), 32'd1);
    chk("wr_mem_we",    32'(bus.mem_we), 32'd1);
    chk("wr_mem_addr",  32'(bus.mem_addr), 32'h100);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h5C);
    chk("b2b_valid_a3", 32'(bus.disp_valid), 32'd1);
    chk("b2b_rdata_a3", 32'(bus.disp_rdata), 32'h33);
    tick;
    chk("wr_single",    32'(bus.mem_en), 32'd0);
    chk("wr_ram_value", 32'(mem_model[256]), 32'h5C);

    // Out-of-range writer and display addresses
    bus.wr_req  = 1'b1;
    bus.wr_addr = 15'(FB_WORDS);
    bus.wr_data = 8'hFF;
    #1;
    chk("oor_wr_ack", 32'(bus.wr_ack), 32'd1);
    tick;
    bus.wr_req    = 1'b0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'h7FFF;
    chk("oor_wr_mem_en", 32'(bus.mem_en), 32'd0);
    tick;
    bus.disp_req = 1'b0;
    chk("oor_rd_mem_en", 32'(bus.mem_en), 32'd0);
    tick;
    chk("oor_rd_valid", 32'(bus.disp_valid), 32'd1);
    chk("oor_rd_rdata", 32'(bus.disp_rdata), 32'd0);
    tick;

    // Full clear, no other traffic; a second clr_start mid-clear must be ignored
    bus.clr_color = 8'hE0;
    bus.clr_start = 1'b1;
    #1;
    chk("clr_busy_start", 32'(bus.clr_busy), 32'd0);
    tick;
    errs = 0;
    busy_cnt = 0;
    for (int j = 0; j < FB_WORDS + 2; j++) begin
      bus.clr_start = (j == 100);
      bus.clr_color = (j == 100) ? 8'h11 : 8'hE0;
      exp_wr = (j >= 1) && (j <= FB_WORDS);
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_busy !== (j <= FB_WORDS - 1)) errs++;
      if (bus.mem_en !== exp_wr) errs++;
      if (exp_wr && (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'(j - 1) || bus.mem_wdata !== 8'hE0))
        errs++;
      tick;
    end
    bus.clr_start = 1'b0;
    chk("clr_seq_errs",  32'(errs), 32'd0);
    chk("clr_busy_cnt",  32'(busy_cnt), 32'd19200);
    chk("clr_ram_first", 32'(mem_model[0]), 32'hE0);
    chk("clr_ram_last",  32'(mem_model[FB_WORDS-1]), 32'hE0);
    chk("clr_ram_wrpix", 32'(mem_model[256]), 32'hE0);

    // Clear with a display read every fourth cycle
    bus.clr_color = 8'h3C;
    bus.clr_start = 1'b1;
    tick;
    bus.clr_start = 1'b0;
    errs = 0;
    busy_cnt = 0;
    wr_cnt = 0;
    for (int j = 0; j < 25604; j++) begin
      bus.disp_req  = (j < 25600) && (j % 4 == 0);
      bus.disp_addr = 15'(j % FB_WORDS);
      exp_valid = (j >= 2) && ((j - 2) % 4 == 0) && (j - 2 < 25600);
      if (bus.clr_busy === 1'b1) busy_cnt++;
      if (bus.clr_busy !== (j <= 25599)) errs++;
      if (bus.disp_valid !== exp_valid) errs++;
      if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) wr_cnt++;
      tick;
    end
    bus.disp_req = 1'b0;
    chk("clrd_errs",     32'(errs), 32'd0);
    chk("clrd_busy_cnt", 32'(busy_cnt), 32'd25600);
    chk("clrd_writes",   32'(wr_cnt), 32'd19200);
    chk("clrd_ram_last", 32'(mem_model[FB_WORDS-1]), 32'h3C);

    // Reset in the middle of a clear
    bus.clr_color = 8'h5A;
    bus.clr_start = 1'b1;
    tick;
    bus.clr_start = 1'b0;
    for (int j = 0; j < 501; j++) tick;
    chk("rstc_mem_addr_pre", 32'(bus.mem_addr), 32'd500);
    #2 rst_n = 1'b0;
    #1;
    chk("rstc_busy",   32'(bus.clr_busy), 32'd0);
    chk("rstc_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rstc_addr",   32'(bus.mem_addr), 32'd0);
    tick;
    #2 rst_n = 1'b1;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'h0005;
    tick;
    bus.disp_req = 1'b0;
    chk("rstc_first_edge", 32'(bus.mem_en), 32'd1);
    chk("rstc_first_addr", 32'(bus.mem_addr), 32'h5);
    errs = 0;
    for (int j = 0; j < 50; j++) begin
      tick;
      if (bus.mem_en !== 1'b0 || bus.clr_busy !== 1'b0) errs++;
    end
    chk("rstc_no_resume", 32'(errs), 32'd0);
    chk("rstc_ram_500",   32'(mem_model[500]), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter FB_WORDS, default 19200, framebuffer depth in words (160x120 pixels, one RGB332 byte each).
REQ-002 SHALL have parameter ADDR_W, default 15, address width.
REQ-003 SHALL have parameter DATA_W, default 8, pixel width (RGB332).
REQ-004 SHALL have port clk_pixel  input  1  pixel clock; the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port disp_req  input  1  scanout read request, single-cycle, no handshake.
REQ-007 SHALL have port disp_addr  input  ADDR_W  scanout read address.
REQ-008 SHALL have port disp_rdata  output  DATA_W  scanout read data.
REQ-009 SHALL have port disp_valid  output  1  disp_rdata valid strobe.
REQ-010 SHALL have port wr_req  input  1  drawing-writer request, held until accepted.
REQ-011 SHALL have port wr_addr  input  ADDR_W  writer address.
REQ-012 SHALL have port wr_data  input  DATA_W  writer data.
REQ-013 SHALL have port wr_ack  output  1  writer request accepted this cycle.
REQ-014 SHALL have port clr_start  input  1  start full-framebuffer clear.
REQ-015 SHALL have port clr_color  input  DATA_W  clear fill value.
REQ-016 SHALL have port clr_busy  output  1  clear in progress.
REQ-017 SHALL have ports mem_en, mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W), mem_rdata (input DATA_W): single-port synchronous RAM, read data one cycle after mem_en.

Function
REQ-018 SHALL arbitrate per cycle with fixed priority: display read > writer > clear engine; exactly one grant or none per cycle.
REQ-019 SHALL grant display unconditionally whenever disp_req=1; display never stalls.
REQ-020 SHALL drive wr_ack combinationally = wr_req & ~disp_req; writer transfer occurs on the clk_pixel edge where wr_req=wr_ack=1.
REQ-021 SHALL register mem_en/mem_we/mem_addr/mem_wdata from the granted source: request in cycle N appears on mem_* in cycle N+1; mem_en=0 when no grant.
REQ-022 SHALL assert disp_valid in cycle N+2 for a display request in cycle N, with disp_rdata = mem_rdata in that cycle; back-to-back display requests give back-to-back disp_valid.
REQ-023 SHALL treat addresses >= FB_WORDS as out of range: writer request acked, mem_en stays 0 (write dropped); display request produces disp_valid at N+2 with disp_rdata=0, mem_en stays 0.
REQ-024 SHALL implement clear FSM states IDLE and CLEAR.
REQ-025 SHALL, in IDLE with clr_start=1, latch clr_color, reset clear counter to 0, enter CLEAR; clr_busy=1 from the next cycle.
REQ-026 SHALL, in CLEAR, issue a write of latched color to counter address in every cycle with neither disp_req nor wr_req, then increment counter.
REQ-027 SHALL, when clear write at address FB_WORDS-1 is issued, return to IDLE; clr_busy=0 the following cycle; counter never exceeds FB_WORDS-1.
REQ-028 SHALL ignore clr_start while in CLEAR (no restart, color unchanged).
REQ-029 SHALL let writer requests preempt the clear; writer pixels to addresses not yet cleared are later overwritten by the clear (documented behaviour).
REQ-030 SHALL hold disp_rdata at 0 when disp_valid=0.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_valid=0, disp_rdata=0, clr_busy=0, FSM=IDLE, counter=0, latched color=0, read pipeline flushed.
REQ-032 SHALL abort an in-progress clear on reset; no resume after release.
REQ-033 SHALL, after rst_n rises, accept requests from the first clk_pixel edge.

Verification
REQ-034 SHALL test: disp_req cycle 10 addr 0x0005, RAM holds 0xA7 -> mem_en/addr 0x0005 cycle 11, disp_valid & disp_rdata=0xA7 cycle 12.
REQ-035 SHALL test: wr_req with disp_req both high 3 cycles, then disp_req low -> wr_ack=0 for 3 cycles, 1 on cycle 4; single write seen on mem_*.
REQ-036 SHALL test: clr_start with clr_color=0xE0, no other traffic -> 19200 consecutive writes addr 0..19199, value 0xE0; clr_busy high exactly 19200 cycles.
REQ-037 SHALL test: disp_req every 4th cycle during clear -> clear completes in 25600 cycles, all display reads valid at N+2.
REQ-038 SHALL test: wr_addr=19200 and disp_addr=0x7FFF -> wr_ack=1, mem_en stays 0; disp_valid with disp_rdata=0x00.
REQ-039 SHALL test: rst_n low at clear counter 500 -> clr_busy=0 and mem_en=0 immediately; no further clear writes after release.
